// File: rtl/alu_rr_sequencer.sv
// Round-robin sequencer sharing one 4-op ALU between two requesters.
// Optional rsp_zero/rsp_carry outputs are enabled by defining ALU_RR_SEQUENCER_FLAGS_EN.
module alu_rr_sequencer #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [1:0]       req0_op,
  input  logic [WIDTH-1:0] req0_a,
  input  logic [WIDTH-1:0] req0_b,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [1:0]       req1_op,
  input  logic [WIDTH-1:0] req1_a,
  input  logic [WIDTH-1:0] req1_b,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic             rsp_id,
  output logic [WIDTH-1:0] rsp_data,
  output logic             busy
`ifdef ALU_RR_SEQUENCER_FLAGS_EN
  ,
  output logic             rsp_zero,
  output logic             rsp_carry
`endif
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t           state, state_nx;
  logic             last_grant;
  logic             grant;
  logic             any_valid;
  logic             accept;
  logic [1:0]       op_q;
  logic [WIDTH-1:0] a_q, b_q;
  logic             id_q;
  logic [WIDTH-1:0] alu_res;

  // Under contention the requester that did not own the last response wins.
  always_comb begin
    any_valid = req0_valid | req1_valid;
    grant     = 1'b0;
    if (req0_valid && req1_valid) grant = ~last_grant;
    else                          grant = req1_valid;
  end

  always_comb begin
    state_nx   = state;
    req0_ready = 1'b0;
    req1_ready = 1'b0;
    accept     = 1'b0;
    busy       = (state != IDLE);
    rsp_valid  = (state == RESP);
    case (state)
      IDLE: begin
        if (any_valid) begin
          accept     = 1'b1;
          req0_ready = ~grant;
          req1_ready = grant;
          state_nx   = EXEC;
        end
      end
      EXEC:    state_nx = RESP;
      RESP:    if (rsp_ready) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_comb begin
    alu_res = '0;
    case (op_q)
      2'd0:    alu_res = a_q + b_q;
      2'd1:    alu_res = a_q >> 2;
      2'd2:    alu_res = a_q - b_q;
      default: alu_res = a_q;
    endcase
  end

`ifdef ALU_RR_SEQUENCER_FLAGS_EN
  logic alu_carry;
  // A wrapped sum smaller than an addend means the add carried out.
  always_comb begin
    alu_carry = 1'b0;
    case (op_q)
      2'd0:    alu_carry = (alu_res < a_q);
      2'd2:    alu_carry = (a_q < b_q);
      default: alu_carry = 1'b0;
    endcase
  end
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      last_grant <= 1'b1;
      op_q       <= '0;
      a_q        <= '0;
      b_q        <= '0;
      id_q       <= 1'b0;
      rsp_data   <= '0;
      rsp_id     <= 1'b0;
`ifdef ALU_RR_SEQUENCER_FLAGS_EN
      rsp_zero   <= 1'b0;
      rsp_carry  <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            id_q <= grant;
            op_q <= grant ? req1_op : req0_op;
            a_q  <= grant ? req1_a  : req0_a;
            b_q  <= grant ? req1_b  : req0_b;
          end
        end
        EXEC: begin
          rsp_data  <= alu_res;
          rsp_id    <= id_q;
`ifdef ALU_RR_SEQUENCER_FLAGS_EN
          rsp_zero  <= (alu_res == '0);
          rsp_carry <= alu_carry;
`endif
        end
        RESP: begin
          if (rsp_ready) last_grant <= rsp_id;
        end
        default: ;
      endcase
    end
  end

endmodule
